// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: frame geometry, synchronizer depth, state encoding
// and command codes, used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

  localparam int PS2_FRAME_BITS  = 10;
  localparam int PS2_SYNC_STAGES = 2;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  localparam logic [5:0] ST_IDLE      = 6'b000001;
  localparam logic [5:0] ST_INHIBIT   = 6'b000010;
  localparam logic [5:0] ST_REQ       = 6'b000100;
  localparam logic [5:0] ST_SEND      = 6'b001000;
  localparam logic [5:0] ST_ACK       = 6'b010000;
  localparam logic [5:0] ST_WAIT_IDLE = 6'b100000;

  typedef enum logic [5:0] {
    S_IDLE      = ST_IDLE,
    S_INHIBIT   = ST_INHIBIT,
    S_REQ       = ST_REQ,
    S_SEND      = ST_SEND,
    S_ACK       = ST_ACK,
    S_WAIT_IDLE = ST_WAIT_IDLE
  } ps2_tx_state_t;

  // {stop, odd parity, data} shifted out LSB first after the start bit
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status between game logic (master) and the PS/2 transmitter (slave).
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output tx_data, tx_valid, input tx_ready, busy, done, error);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, error);
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// Synchronizes the raw PS/2 clock and data pins and produces a registered
// one-cycle pulse on each falling edge of the synchronized clock.
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [PS2_SYNC_STAGES-1:0] clk_ff;
  logic [PS2_SYNC_STAGES-1:0] dat_ff;
  logic                       clk_prev;

  assign clk_sync = clk_ff[PS2_SYNC_STAGES-1];
  assign dat_sync = dat_ff[PS2_SYNC_STAGES-1];

  // idle bus is high, so reset to 1 to avoid a false edge on release
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_ff   <= '1;
      dat_ff   <= '1;
      clk_prev <= 1'b1;
      clk_fall <= 1'b0;
    end else begin
      clk_ff   <= {clk_ff[PS2_SYNC_STAGES-2:0], ps2_clk_in};
      dat_ff   <= {dat_ff[PS2_SYNC_STAGES-2:0], ps2_dat_in};
      clk_prev <= clk_sync;
      clk_fall <= clk_prev & ~clk_sync;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, then device ACK, over open-drain clock/data lines.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | lines released, ready for a command byte
//   INHIBIT   | clock held low for INHIBIT_CYCLES
//   REQ       | clock and data both low (request-to-send)
//   SEND      | clock released, shift frame bits on device clock falls
//   ACK       | sample device ACK bit on the next clock fall
//   WAIT_IDLE | wait for both lines high, then report the result
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  ps2_tx_state_t             state;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic [3:0]                bit_idx;
  logic [INH_W-1:0]          inh_cnt;
  logic [WD_W-1:0]           wd_cnt;
  logic                      nack;

  logic clk_sync;
  logic dat_sync;
  logic clk_fall;
  logic wd_active;
  logic wd_zero;

  ps2_line_sync u_line_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_sync   (clk_sync),
    .dat_sync   (dat_sync),
    .clk_fall   (clk_fall)
  );

  assign wd_active = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign wd_zero   = (wd_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      frame       <= '0;
      bit_idx     <= '0;
      inh_cnt     <= '0;
      wd_cnt      <= '0;
      nack        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_dat_oe  <= 1'b0;
      tx.tx_ready <= 1'b1;
      tx.busy     <= 1'b0;
      tx.done     <= 1'b0;
      tx.error    <= 1'b0;
    end else begin
      tx.done  <= 1'b0;
      tx.error <= 1'b0;
      if (wd_active && wd_zero) begin
        // device stopped clocking: abandon the frame
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        tx.error   <= 1'b1;
        tx.busy    <= 1'b0;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            ps2_clk_oe  <= 1'b0;
            ps2_dat_oe  <= 1'b0;
            tx.busy     <= 1'b0;
            tx.tx_ready <= 1'b1;
            if (tx.tx_valid && tx.tx_ready) begin
              frame       <= ps2_build_frame(tx.tx_data);
              inh_cnt     <= INH_W'(INHIBIT_CYCLES - 1);
              bit_idx     <= '0;
              wd_cnt      <= '0;
              nack        <= 1'b0;
              tx.tx_ready <= 1'b0;
              state       <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            ps2_clk_oe <= 1'b1;
            tx.busy    <= 1'b1;
            if (inh_cnt == '0) begin
              ps2_dat_oe <= 1'b1;
              state      <= S_REQ;
            end else begin
              inh_cnt <= inh_cnt - 1'b1;
            end
          end
          S_REQ: begin
            ps2_clk_oe <= 1'b0;
            bit_idx    <= '0;
            wd_cnt     <= WD_W'(TIMEOUT_CYCLES - 1);
            state      <= S_SEND;
          end
          S_SEND: begin
            wd_cnt <= wd_cnt - 1'b1;
            if (clk_fall) begin
              ps2_dat_oe <= ~frame[bit_idx];
              if (bit_idx == 4'(PS2_FRAME_BITS - 1)) state <= S_ACK;
              else bit_idx <= bit_idx + 1'b1;
            end
          end
          S_ACK: begin
            wd_cnt <= wd_cnt - 1'b1;
            if (clk_fall) begin
              nack  <= dat_sync;
              state <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            wd_cnt <= wd_cnt - 1'b1;
            if (clk_sync && dat_sync) begin
              tx.done  <= ~nack;
              tx.error <= nack;
              tx.busy  <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: table of command frames against a simple
// open-drain PS/2 device model, plus timeout, reset-abort and back-to-back cases.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 60;
  localparam int TMO = 3000;
  localparam int H   = 25;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         hold;
    logic [9:0] exp_frame;
    bit         exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk_oe, ps2_dat_oe;
  logic ps2_clk_line, ps2_dat_line;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int last_acc_cyc = 0, last_done_cyc = 0, last_err_cyc = 0;
  int dev_release_cyc = 0;

  ps2_host_tx_if bus ();

  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx         (bus),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && bus.tx_valid && bus.tx_ready) begin
      acc_cnt      <= acc_cnt + 1;
      last_acc_cyc <= cyc + 1;
    end
    if (bus.done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (bus.error) begin
      err_cnt      <= err_cnt + 1;
      last_err_cyc <= cyc;
    end
    if (bus.done && bus.error) both_cnt <= both_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [7:0] data, input bit keep_valid, output int rel);
    int n;
    int acc_edge;
    bus.tx_data  = data;
    bus.tx_valid = 1'b1;
    n = 0;
    while (!bus.tx_ready && n < 100) begin step(); n++; end
    check("accept_ready", 32'(bus.tx_ready), 1);
    step();
    acc_edge = cyc;
    if (!keep_valid) bus.tx_valid = 1'b0;
    check("ready_drops", 32'(bus.tx_ready), 0);
    check("clk_oe_at_accept", 32'(ps2_clk_oe), 0);
    step();
    check("inhibit_start", 32'({ps2_clk_oe, bus.busy}), 32'h3);
    n = 0;
    while (!ps2_dat_oe && n < INH + 20) begin step(); n++; end
    check("dat_oe_rise_delay", 32'(cyc - acc_edge), INH);
    check("clk_held_low", 32'(ps2_clk_oe), 1);
    step();
    check("clk_release", 32'(ps2_clk_oe), 0);
    rel = cyc;
  endtask

  // device clocks 11 pulses; bits sampled at the end of each low phase
  task automatic dev_frame(input bit ack, input int hold, input int abort_after,
                           output logic [9:0] bits);
    int p0;
    bits = '0;
    repeat (H) step();
    for (int i = 1; i <= 11; i++) begin
      if (i - 1 == abort_after) return;
      if (i == 11) begin
        if (ack) dev_dat_low = 1'b1;
        repeat (H) step();
      end
      dev_clk_low = 1'b1;
      repeat (H) step();
      if (i <= 10) bits[i-1] = ps2_dat_line;
      if (i == 11 && hold > 0) begin
        p0 = done_cnt + err_cnt;
        repeat (hold) step();
        check("hold_no_pulse", 32'(done_cnt + err_cnt - p0), 0);
      end
      dev_clk_low = 1'b0;
      if (i == 11) begin
        dev_dat_low = 1'b0;
        dev_release_cyc = cyc;
      end
      repeat (H) step();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int rel, n, d0, e0, lat;
    logic [9:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(v.data, 1'b0, rel);
    check("start_bit", 32'(ps2_dat_line), 0);
    dev_frame(v.ack, v.hold, -1, bits);
    check("frame_bits", 32'(bits), 32'(v.exp_frame));
    n = 0;
    while (done_cnt + err_cnt == d0 + e0 && n < 50) begin step(); n++; end
    check("done_pulse", 32'(done_cnt - d0), 32'(v.exp_done));
    check("error_pulse", 32'(err_cnt - e0), 32'(!v.exp_done));
    lat = v.exp_done ? last_done_cyc - dev_release_cyc : last_err_cyc - dev_release_cyc;
    check("result_latency_3_4", 32'(lat >= 3 && lat <= 4), 1);
    check("lines_released", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    check("ready_after", 32'(bus.tx_ready), 1);
  endtask

  vec_t vecs[6];

  initial begin
    int rel, n, d0, e0, a0;
    logic [9:0] bits;

    vecs[0] = '{8'hED, 1'b1, 0,  10'h3ED, 1'b1};
    vecs[1] = '{8'hF4, 1'b0, 0,  10'h2F4, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 0,  10'h3FF, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 0,  10'h300, 1'b1};
    vecs[4] = '{8'hFA, 1'b1, 80, 10'h3FA, 1'b1};
    vecs[5] = '{8'h01, 1'b0, 0,  10'h201, 1'b0};

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) step();
    check("reset_state",
          32'({bus.tx_ready, bus.busy, ps2_clk_oe, ps2_dat_oe, bus.done, bus.error}),
          32'b100000);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // device never clocks
    e0 = err_cnt;
    d0 = done_cnt;
    start_tx(8'hF4, 1'b0, rel);
    n = 0;
    while (!bus.error && n < TMO + 20) begin step(); n++; end
    check("timeout_delay", 32'(cyc - rel), TMO);
    check("timeout_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    step();
    check("timeout_counts", 32'({err_cnt - e0, done_cnt - d0}), 32'({32'd1, 32'd0}));

    // reset after the 4th data bit
    d0 = done_cnt + err_cnt;
    start_tx(8'hA5, 1'b0, rel);
    dev_frame(1'b1, 0, 4, bits);
    check("pre_reset_dat_oe", 32'(ps2_dat_oe), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_abort",
          32'({ps2_clk_oe, ps2_dat_oe, bus.tx_ready, bus.busy}), 32'b0010);
    repeat (10) step();
    check("reset_no_pulse", 32'(done_cnt + err_cnt - d0), 0);
    run_vec('{8'hFF, 1'b1, 0, 10'h3FF, 1'b1});

    // tx_valid held across a frame
    a0 = acc_cnt;
    d0 = done_cnt;
    start_tx(8'h55, 1'b1, rel);
    bus.tx_data = 8'hAA;
    dev_frame(1'b1, 0, -1, bits);
    check("b2b_frame", 32'(bits), 32'h355);
    n = 0;
    while (done_cnt == d0 && n < 50) begin step(); n++; end
    check("b2b_done", 32'(done_cnt - d0), 1);
    n = 0;
    while (acc_cnt - a0 < 2 && n < 20) begin step(); n++; end
    check("b2b_accepts", 32'(acc_cnt - a0), 2);
    check("b2b_accept_after_done", 32'(last_acc_cyc - last_done_cyc), 2);
    bus.tx_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    check("done_error_exclusive", 32'(both_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
